// File: rtl/frame_windower_pkg.sv
// Shared constants, state encoding and Hann quarter-wave table for the frame windower.
package frame_windower_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned COEF_W    = 16;
  localparam int unsigned FRAME_LEN = 64;
  localparam int unsigned HOP       = 32;
  localparam int unsigned SRC_AW    = 10;
  localparam int unsigned FRM_AW    = 6;
  localparam int unsigned PROD_W    = DATA_W + COEF_W + 1;

  localparam logic [COEF_W-1:0]        COEF_MAX = COEF_W'(32767);
  localparam logic signed [PROD_W-1:0] ROUND_K  = PROD_W'(1 << 14);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StWaitAck,
    StAdvance,
    StDone
  } state_e;

  // round(32767 * 0.5 * (1 - cos(2*pi*n/64))) for n = 0..16; the rest follows by symmetry.
  function automatic logic [COEF_W-1:0] quarter_coef(input logic [4:0] n);
    logic [COEF_W-1:0] w;
    case (n)
      5'd0:    w = 16'd0;
      5'd1:    w = 16'd79;
      5'd2:    w = 16'd315;
      5'd3:    w = 16'd705;
      5'd4:    w = 16'd1247;
      5'd5:    w = 16'd1935;
      5'd6:    w = 16'd2761;
      5'd7:    w = 16'd3719;
      5'd8:    w = 16'd4799;
      5'd9:    w = 16'd5990;
      5'd10:   w = 16'd7281;
      5'd11:   w = 16'd8660;
      5'd12:   w = 16'd10114;
      5'd13:   w = 16'd11628;
      5'd14:   w = 16'd13187;
      5'd15:   w = 16'd14778;
      5'd16:   w = 16'd16384;
      default: w = 16'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/frame_windower_hann_rom.sv
// Synchronous periodic-Hann coefficient ROM, one-cycle read latency.
module hann_rom
  import frame_windower_pkg::*;
(
  input  logic              clk,
  input  logic [FRM_AW-1:0] addr,
  output logic [COEF_W-1:0] coef
);

  localparam logic [FRM_AW-1:0] Half    = FRM_AW'(FRAME_LEN / 2);
  localparam logic [FRM_AW-1:0] Quarter = FRM_AW'(FRAME_LEN / 4);

  logic [FRM_AW-1:0] fold;
  logic [COEF_W-1:0] coef_d;

  // w[n] = w[64-n], and w[32-m] = 32767 - w[m] for the second quarter.
  always_comb begin
    fold = (addr > Half) ? (FRM_AW'(0) - addr) : addr;
    if (fold > Quarter) begin
      coef_d = COEF_MAX - quarter_coef(5'(Half - fold));
    end else begin
      coef_d = quarter_coef(5'(fold));
    end
  end

  always_ff @(posedge clk) begin
    coef <= coef_d;
  end

endmodule

// File: rtl/frame_windower.sv
// Reads overlapping 64-sample frames (hop 32), applies the Hann window and hands each
// frame to the FFT controller through a valid/ack handshake.
module frame_windower
  import frame_windower_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SRC_AW:0]   num_samples,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] src_dout,
  output logic              win_we,
  output logic [FRM_AW-1:0] win_addr,
  output logic [DATA_W-1:0] win_din,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_count
);

  localparam logic [SRC_AW:0]   FrameLenS = (SRC_AW + 1)'(FRAME_LEN);
  localparam logic [SRC_AW:0]   HopS      = (SRC_AW + 1)'(HOP);
  localparam logic [FRM_AW-1:0] LastK     = FRM_AW'(FRAME_LEN - 1);
  localparam logic [SRC_AW+1:0] NextSpan  = (SRC_AW + 2)'(HOP + FRAME_LEN);

  state_e state_q, state_d;

  logic [SRC_AW:0]   num_q;
  logic [SRC_AW:0]   base_q;
  logic [FRM_AW-1:0] k_q;
  logic              drain_q;
  logic              v1_q;
  logic [FRM_AW-1:0] k1_q;
  logic              win_we_q;
  logic [FRM_AW-1:0] win_addr_q;
  logic [DATA_W-1:0] win_din_q;
  logic [7:0]        frame_count_q;

  logic              fetch;
  logic              accept;
  logic              last_frame;
  logic [COEF_W-1:0] coef;

  logic signed [PROD_W-1:0] x_ext, c_ext, prod, rounded;
  logic [DATA_W-1:0]        scaled;

  hann_rom u_hann_rom (
    .clk  (clk),
    .addr (k_q),
    .coef (coef)
  );

  assign accept     = (state_q == StIdle) && start;
  // Would the frame after the current one run past the valid samples?
  assign last_frame = ({1'b0, base_q} + NextSpan) > {1'b0, num_q};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = (num_samples < FrameLenS) ? StDone : StFetch;
      StFetch:   if (k_q == LastK) state_d = StDrain;
      StDrain:   if (drain_q) state_d = StWaitAck;
      StWaitAck: if (frame_ack) state_d = StAdvance;
      StAdvance: state_d = last_frame ? StDone : StFetch;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    fetch       = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    frame_valid = 1'b0;
    unique case (state_q)
      StIdle:    busy = 1'b0;
      StFetch:   fetch = 1'b1;
      StWaitAck: frame_valid = 1'b1;
      StDone:    done = 1'b1;
      default:   ;
    endcase
  end

  // Q1.15 scaling: round half up, then arithmetic shift; coef < 1.0 so no overflow.
  always_comb begin
    x_ext   = PROD_W'($signed(src_dout));
    c_ext   = PROD_W'($signed({1'b0, coef}));
    prod    = x_ext * c_ext;
    rounded = prod + ROUND_K;
    scaled  = DATA_W'(rounded >>> 15);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q         <= '0;
      base_q        <= '0;
      k_q           <= '0;
      drain_q       <= 1'b0;
      v1_q          <= 1'b0;
      k1_q          <= '0;
      win_we_q      <= 1'b0;
      win_addr_q    <= '0;
      win_din_q     <= '0;
      frame_count_q <= '0;
    end else begin
      if (accept) begin
        num_q         <= num_samples;
        base_q        <= '0;
        frame_count_q <= '0;
      end
      if (state_q == StAdvance) begin
        base_q <= base_q + HopS;
      end
      if (state_q == StDrain && drain_q) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
      k_q        <= fetch ? k_q + FRM_AW'(1) : '0;
      drain_q    <= (state_q == StDrain) ? ~drain_q : 1'b0;
      v1_q       <= fetch;
      k1_q       <= k_q;
      win_we_q   <= v1_q;
      win_addr_q <= k1_q;
      if (v1_q) begin
        win_din_q <= scaled;
      end
    end
  end

  assign src_addr    = SRC_AW'(base_q) + SRC_AW'(k_q);
  assign win_we      = win_we_q;
  assign win_addr    = win_addr_q;
  assign win_din     = win_din_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_windower.sv
// Directed testbench for frame_windower with source/window RAM models.
module tb_frame_windower;
  import frame_windower_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              frame_ack = 1'b0;
  logic [SRC_AW:0]   num_samples = '0;
  logic [SRC_AW-1:0] src_addr;
  logic [DATA_W-1:0] src_dout;
  logic              win_we;
  logic [FRM_AW-1:0] win_addr;
  logic [DATA_W-1:0] win_din;
  logic              frame_valid;
  logic              busy;
  logic              done;
  logic [7:0]        frame_count;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] src_mem [1024];
  logic [DATA_W-1:0] win_mem [FRAME_LEN];
  int wr_total = 0;
  int wr_in_valid = 0;
  int done_total = 0;

  frame_windower dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .src_addr    (src_addr),
    .src_dout    (src_dout),
    .win_we      (win_we),
    .win_addr    (win_addr),
    .win_din     (win_din),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) src_dout <= src_mem[src_addr];

  always @(posedge clk) begin
    if (win_we === 1'b1) begin
      win_mem[win_addr] <= win_din;
      wr_total <= wr_total + 1;
      if (frame_valid === 1'b1) wr_in_valid <= wr_in_valid + 1;
    end
  end

  always @(negedge clk) if (done === 1'b1) done_total <= done_total + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input int val);
    for (int i = 0; i < 1024; i++) src_mem[i] = DATA_W'(val);
  endtask

  task automatic fill_ramp(input int scale);
    for (int i = 0; i < 1024; i++) src_mem[i] = DATA_W'(i * scale);
  endtask

  // Returns at the negedge of cycle 1 (start accepted at the end of cycle 0).
  task automatic pulse_start(input int n);
    start = 1'b1;
    num_samples = (SRC_AW + 1)'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (frame_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid_timeout"}, frame_valid, 1);
  endtask

  task automatic ack_frame(input string tag);
    repeat (5) @(negedge clk);
    check({tag, " valid_held"}, frame_valid, 1);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    check({tag, " valid_fall"}, frame_valid, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle_timeout"}, busy, 0);
  endtask

  initial begin
    int wr0, d0, drops, moved;
    logic [SRC_AW-1:0] sa;

    fill_const(1000);
    repeat (3) @(negedge clk);
    check("rst src_addr", src_addr, 0);
    check("rst win_we", win_we, 0);
    check("rst win_addr", win_addr, 0);
    check("rst win_din", win_din, 0);
    check("rst frame_valid", frame_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst frame_count", frame_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Pass 1: constant 1000, full 1024-sample buffer, with cycle-exact first frame.
    wr0 = wr_total;
    d0 = done_total;
    pulse_start(1024);
    check("p1 busy c1", busy, 1);
    check("p1 src_addr c1", src_addr, 0);
    check("p1 win_we c1", win_we, 0);
    @(negedge clk);
    check("p1 src_addr c2", src_addr, 1);
    @(negedge clk);
    check("p1 win_we c3", win_we, 1);
    check("p1 win_addr c3", win_addr, 0);
    check("p1 win_din c3", win_din, 0);
    repeat (63) @(negedge clk);
    check("p1 win_we c66", win_we, 1);
    check("p1 win_addr c66", win_addr, 63);
    check("p1 win_din c66", win_din, 2);
    check("p1 valid c66", frame_valid, 0);
    @(negedge clk);
    check("p1 valid c67", frame_valid, 1);
    check("p1 win_we c67", win_we, 0);
    check("p1 count c67", frame_count, 1);
    check("p1 writes f1", wr_total - wr0, 64);
    for (int f = 1; f <= 31; f++) begin
      if (f > 1) wait_valid($sformatf("p1 f%0d", f));
      check($sformatf("p1 f%0d win0", f), $signed(win_mem[0]), 0);
      check($sformatf("p1 f%0d win16", f), $signed(win_mem[16]), 500);
      check($sformatf("p1 f%0d win32", f), $signed(win_mem[32]), 1000);
      check($sformatf("p1 f%0d win48", f), $signed(win_mem[48]), 500);
      check($sformatf("p1 f%0d count", f), frame_count, f);
      ack_frame($sformatf("p1 f%0d", f));
    end
    wait_idle("p1");
    check("p1 done pulses", done_total - d0, 1);
    check("p1 frame_count", frame_count, 31);
    check("p1 total writes", wr_total - wr0, 31 * 64);
    check("p1 writes in valid", wr_in_valid, 0);

    // Pass 2: constant -1000, 2 frames; ack held high during fetch must be ignored.
    fill_const(-1000);
    pulse_start(96);
    frame_ack = 1'b1;
    repeat (10) @(negedge clk);
    frame_ack = 1'b0;
    repeat (56) @(negedge clk);
    check("p2 valid c67", frame_valid, 1);
    for (int f = 1; f <= 2; f++) begin
      if (f > 1) wait_valid($sformatf("p2 f%0d", f));
      check($sformatf("p2 f%0d win0", f), $signed(win_mem[0]), 0);
      check($sformatf("p2 f%0d win16", f), $signed(win_mem[16]), -500);
      check($sformatf("p2 f%0d win32", f), $signed(win_mem[32]), -1000);
      ack_frame($sformatf("p2 f%0d", f));
    end
    wait_idle("p2");
    check("p2 frame_count", frame_count, 2);

    // Pass 3: ramp x[i]=i, 3 frames at bases 0, 32, 64.
    fill_ramp(1);
    pulse_start(128);
    for (int f = 0; f < 3; f++) begin
      wait_valid($sformatf("p3 f%0d", f));
      check($sformatf("p3 f%0d win32", f), $signed(win_mem[32]), 32 * (f + 1));
      check($sformatf("p3 f%0d win16", f), $signed(win_mem[16]), 8 + 16 * f);
      ack_frame($sformatf("p3 f%0d", f));
    end
    wait_idle("p3");
    check("p3 frame_count", frame_count, 3);

    // Pass 4: too few samples for one frame.
    wr0 = wr_total;
    d0 = done_total;
    pulse_start(63);
    check("p4 count c1", frame_count, 0);
    repeat (3) @(negedge clk);
    check("p4 done pulses", done_total - d0, 1);
    check("p4 writes", wr_total - wr0, 0);
    check("p4 busy", busy, 0);
    check("p4 frame_count", frame_count, 0);

    // Pass 5: ack withheld for 1000 cycles.
    fill_const(1000);
    d0 = done_total;
    pulse_start(64);
    wait_valid("p5");
    sa = src_addr;
    wr0 = wr_total;
    drops = 0;
    moved = 0;
    repeat (1000) begin
      @(negedge clk);
      if (frame_valid !== 1'b1) drops++;
      if (src_addr !== sa) moved++;
    end
    check("p5 valid drops", drops, 0);
    check("p5 src_addr moves", moved, 0);
    check("p5 writes while waiting", wr_total - wr0, 0);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    wait_idle("p5");
    check("p5 frame_count", frame_count, 1);
    check("p5 done pulses", done_total - d0, 1);

    // Pass 6: reset at cycle 40 of frame 1, then a fresh pass from base 0.
    fill_ramp(1);
    pulse_start(1024);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("p6 rst win_we", win_we, 0);
    check("p6 rst busy", busy, 0);
    check("p6 rst src_addr", src_addr, 0);
    check("p6 rst valid", frame_valid, 0);
    check("p6 rst count", frame_count, 0);
    wr0 = wr_total;
    rst = 1'b0;
    fill_ramp(2);
    repeat (5) @(negedge clk);
    check("p6 writes after rst", wr_total - wr0, 0);
    pulse_start(96);
    wait_valid("p6 f0");
    check("p6 f0 writes", wr_total - wr0, 64);
    check("p6 f0 win0", $signed(win_mem[0]), 0);
    check("p6 f0 win16", $signed(win_mem[16]), 16);
    check("p6 f0 win32", $signed(win_mem[32]), 64);
    ack_frame("p6 f0");
    wait_valid("p6 f1");
    check("p6 f1 win16", $signed(win_mem[16]), 48);
    check("p6 f1 win32", $signed(win_mem[32]), 128);
    ack_frame("p6 f1");
    wait_idle("p6");
    check("p6 frame_count", frame_count, 2);
    check("p6 writes in valid", wr_in_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
